// File: rtl/uart_tx_if.sv
// UART transmitter bus bundle: THR/LCR/FCR controls in, serial line and LSR/FCR status out.
// The bus side drives through the master modport, the transmitter uses the slave modport.
interface uart_tx_if;
    logic       baud_tick_i;
    logic [7:0] thr_i;
    logic       thr_write_i;
    logic [7:0] lcr_i;
    logic       fifo_en_i;
    logic       tx_fifo_rst_i;
    logic       tx_o;
    logic       thr_empty_o;
    logic       thr_valid_o;
    logic       tx_empty_o;
    logic       empty_valid_o;
    logic       fifo_rst_o;
    logic       fifo_rst_valid_o;

    modport master (
        output baud_tick_i, thr_i, thr_write_i, lcr_i, fifo_en_i, tx_fifo_rst_i,
        input  tx_o, thr_empty_o, thr_valid_o, tx_empty_o, empty_valid_o,
               fifo_rst_o, fifo_rst_valid_o
    );

    modport slave (
        input  baud_tick_i, thr_i, thr_write_i, lcr_i, fifo_en_i, tx_fifo_rst_i,
        output tx_o, thr_empty_o, thr_valid_o, tx_empty_o, empty_valid_o,
               fifo_rst_o, fifo_rst_valid_o
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: TX FIFO (FifoDepth entries, capacity 1 when FIFOs are disabled)
// feeding a 16x-oversampled shifter (start, 5..8 data bits LSB first, optional parity,
// 1 / 1.5 / 2 stop bits). Line control is latched when a character is popped.
// Optional feature: define UART_TX_BREAK_EN to let lcr_i[6] force the line low.
module uart_tx #(
    parameter int FifoDepth = 16
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    uart_tx_if.slave  bus
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    // Parity of the low (5 + wlen) bits, with even/odd and stick selection.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wlen,
                                        input logic even, input logic stick);
        logic [7:0] mask;
        logic       x;
        mask = 8'hFF >> (2'd3 - wlen);
        x    = ^(data & mask);
        if (stick) begin
            parity_bit = ~even;
        end else if (even) begin
            parity_bit = x;
        end else begin
            parity_bit = ~x;
        end
    endfunction

    logic [7:0]      mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    logic [3:0]      tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic            seg_q, seg_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [1:0]      wlen_q, wlen_d;
    logic            pen_q, pen_d;
    logic            stop2_q, stop2_d;
    logic            tx_q, tx_d;
    logic            thr_empty_q, thr_empty_d, thr_valid_q, thr_valid_d;
    logic            tx_empty_q, tx_empty_d, empty_valid_q, empty_valid_d;

    logic full_s, nempty_s, push_s, pop_s, tick_last_s, stop_last_s, tx_line_s;
    logic unused_s;

    // FIFO flags and push qualification; a flush blocks both push and pop.
    always_comb begin
        if (bus.fifo_en_i) begin
            full_s = (count_q >= CntW'(FifoDepth));
        end else begin
            full_s = (count_q != {CntW{1'b0}});
        end
        nempty_s = (count_q != {CntW{1'b0}}) && !bus.tx_fifo_rst_i;
        push_s   = bus.thr_write_i && !full_s && !bus.tx_fifo_rst_i;
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.tx_fifo_rst_i) begin
            wr_ptr_d = {PtrW{1'b0}};
            rd_ptr_d = {PtrW{1'b0}};
            count_d  = {CntW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Transmit FSM: next state, tick/bit counters, character load on pop.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        seg_d   = seg_q;
        shift_d = shift_q;
        par_d   = par_q;
        wlen_d  = wlen_q;
        pen_d   = pen_q;
        stop2_d = stop2_q;
        pop_s   = 1'b0;

        tick_last_s = (tick_q == 4'd15);
        if (!stop2_q) begin
            stop_last_s = tick_last_s;
        end else if (wlen_q == 2'd0) begin
            stop_last_s = seg_q && (tick_q == 4'd7);
        end else begin
            stop_last_s = seg_q && tick_last_s;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.baud_tick_i && nempty_s) begin
                    pop_s   = 1'b1;
                    state_d = S_START;
                    tick_d  = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bus.baud_tick_i) begin
                    if (tick_last_s) begin
                        state_d = S_DATA;
                        tick_d  = 4'd0;
                        bit_d   = 3'd0;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
            S_DATA: begin
                if (bus.baud_tick_i) begin
                    if (tick_last_s) begin
                        tick_d = 4'd0;
                        if (bit_q == (3'd4 + {1'b0, wlen_q})) begin
                            state_d = pen_q ? S_PARITY : S_STOP;
                            seg_d   = 1'b0;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
            S_PARITY: begin
                if (bus.baud_tick_i) begin
                    if (tick_last_s) begin
                        state_d = S_STOP;
                        tick_d  = 4'd0;
                        seg_d   = 1'b0;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
            S_STOP: begin
                if (bus.baud_tick_i) begin
                    if (stop_last_s) begin
                        tick_d = 4'd0;
                        seg_d  = 1'b0;
                        if (nempty_s) begin
                            pop_s   = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (tick_last_s) begin
                        tick_d = 4'd0;
                        seg_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = 4'd0;
            end
        endcase

        if (pop_s) begin
            shift_d = mem_q[rd_ptr_q];
            wlen_d  = bus.lcr_i[1:0];
            stop2_d = bus.lcr_i[2];
            pen_d   = bus.lcr_i[3];
            par_d   = parity_bit(mem_q[rd_ptr_q], bus.lcr_i[1:0], bus.lcr_i[4], bus.lcr_i[5]);
        end else begin
            shift_d = shift_d;
        end
    end

    // Line level and status values computed from the next state so outputs are registered.
    always_comb begin
        case (state_d)
            S_IDLE:   tx_line_s = 1'b1;
            S_START:  tx_line_s = 1'b0;
            S_DATA:   tx_line_s = shift_d[0];
            S_PARITY: tx_line_s = par_d;
            S_STOP:   tx_line_s = 1'b1;
            default:  tx_line_s = 1'b1;
        endcase
`ifdef UART_TX_BREAK_EN
        if (bus.lcr_i[6]) begin
            tx_d = 1'b0;
        end else begin
            tx_d = tx_line_s;
        end
`else
        tx_d = tx_line_s;
`endif
        thr_empty_d   = (count_d == {CntW{1'b0}});
        thr_valid_d   = (thr_empty_d != thr_empty_q);
        tx_empty_d    = thr_empty_d && (state_d == S_IDLE);
        empty_valid_d = (tx_empty_d != tx_empty_q);
    end

    // FIFO storage; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.thr_i;
        end
    end

    // State, counters and registered outputs; reset aborts any character in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q      <= {PtrW{1'b0}};
            rd_ptr_q      <= {PtrW{1'b0}};
            count_q       <= {CntW{1'b0}};
            state_q       <= S_IDLE;
            tick_q        <= 4'd0;
            bit_q         <= 3'd0;
            seg_q         <= 1'b0;
            shift_q       <= 8'd0;
            par_q         <= 1'b0;
            wlen_q        <= 2'd0;
            pen_q         <= 1'b0;
            stop2_q       <= 1'b0;
            tx_q          <= 1'b1;
            thr_empty_q   <= 1'b1;
            thr_valid_q   <= 1'b0;
            tx_empty_q    <= 1'b1;
            empty_valid_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            tick_q        <= tick_d;
            bit_q         <= bit_d;
            seg_q         <= seg_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            wlen_q        <= wlen_d;
            pen_q         <= pen_d;
            stop2_q       <= stop2_d;
            tx_q          <= tx_d;
            thr_empty_q   <= thr_empty_d;
            thr_valid_q   <= thr_valid_d;
            tx_empty_q    <= tx_empty_d;
            empty_valid_q <= empty_valid_d;
        end
    end

    assign bus.tx_o             = tx_q;
    assign bus.thr_empty_o      = thr_empty_q;
    assign bus.thr_valid_o      = thr_valid_q;
    assign bus.tx_empty_o       = tx_empty_q;
    assign bus.empty_valid_o    = empty_valid_q;
    // The TX-reset bit self-clears in the same cycle the flush happens.
    assign bus.fifo_rst_o       = 1'b0;
    assign bus.fifo_rst_valid_o = bus.tx_fifo_rst_i;

`ifdef UART_TX_BREAK_EN
    assign unused_s = bus.lcr_i[7];
`else
    assign unused_s = ^bus.lcr_i[7:6];
`endif
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model fed by randomized and
// directed writes; a tick-sampling monitor compares whole frames and line gaps.
module tb_uart_tx;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    uart_tx_if bus ();

    uart_tx #(.FifoDepth(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] lcr;
    } frame_t;

    frame_t exp_q[$];
    int n_checks = 0, n_pass = 0;
    int drops = 0, frames_done = 0;
    int ev_err = 0, th_err = 0, ev_rise = 0, frv_cnt = 0, frv_bad = 0;
    int mon_state = 0, mon_idx = 0, mon_len = 0;
    bit mon_en = 1'b1, tick_en = 1'b1;
    int tdiv = 0;
    logic [255:0] mon_obs, mon_exp;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level per baud tick for one character.
    function automatic void build_frame(input frame_t f, output logic [255:0] v, output int len);
        int wl, stp, mk, ones;
        logic par;
        logic [7:0] m;
        v   = '0;
        len = 16;
        wl  = 5 + int'(f.lcr[1:0]);
        for (int i = 0; i < wl; i++) begin
            for (int k = 0; k < 16; k++) begin
                v[len] = f.data[i];
                len++;
            end
        end
        if (f.lcr[3]) begin
            mk   = (1 << wl) - 1;
            m    = f.data & mk[7:0];
            ones = $countones(m);
            if (f.lcr[5]) par = !f.lcr[4];
            else if (f.lcr[4]) par = (ones % 2) == 1;
            else par = (ones % 2) == 0;
            for (int k = 0; k < 16; k++) begin
                v[len] = par;
                len++;
            end
        end
        stp = !f.lcr[2] ? 16 : (wl == 5 ? 24 : 32);
        for (int k = 0; k < stp; k++) begin
            v[len] = 1'b1;
            len++;
        end
    endfunction

    // Baud tick generator: one pulse every third clock while enabled.
    initial begin
        bus.baud_tick_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tdiv = (tdiv == 2) ? 0 : tdiv + 1;
            bus.baud_tick_i = tick_en && (tdiv == 0);
        end
    end

    // Frame monitor sampling the line on every baud tick.
    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_state = 0;
            end else if (mon_en && bus.baud_tick_i) begin
                if (mon_state == 2) begin
                    if (exp_q.size() > 0) check_eq("gap", bus.tx_o, 1'b0);
                    else check_eq("idle_after_stop", {bus.tx_empty_o, bus.tx_o}, 2'b11);
                    mon_state = 0;
                end else if (mon_state == 1) begin
                    mon_obs[mon_idx] = bus.tx_o;
                    mon_idx++;
                    if (mon_idx == mon_len) begin
                        check_eq("frame", mon_obs, mon_exp);
                        frames_done++;
                        mon_state = 2;
                    end
                end
                if (mon_state == 0 && bus.tx_o == 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_start", bus.tx_o, 1'b1);
                    end else begin
                        f = exp_q.pop_front();
                        build_frame(f, mon_exp, mon_len);
                        mon_obs    = '0;
                        mon_obs[0] = bus.tx_o;
                        mon_idx    = 1;
                        mon_state  = 1;
                        check_eq("thr_empty_at_pop", bus.thr_empty_o, exp_q.size() == 0);
                    end
                end
            end
        end
    end

    // Status strobe rules: each valid pulses exactly when its value changed.
    initial begin
        logic prev_te, prev_th;
        prev_te = 1'b1;
        prev_th = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.empty_valid_o !== (bus.tx_empty_o != prev_te)) ev_err++;
                if (bus.thr_valid_o !== (bus.thr_empty_o != prev_th)) th_err++;
                if (bus.empty_valid_o && bus.tx_empty_o) ev_rise++;
                if (bus.fifo_rst_valid_o) begin
                    frv_cnt++;
                    if (bus.fifo_rst_o !== 1'b0) frv_bad++;
                end
            end
            prev_te = bus.tx_empty_o;
            prev_th = bus.thr_empty_o;
        end
    end

    task automatic push_thr(input logic [7:0] d, input bit model);
        int cap;
        bus.thr_i       = d;
        bus.thr_write_i = 1'b1;
        if (model) begin
            cap = bus.fifo_en_i ? DEPTH : 1;
            if (bus.tx_fifo_rst_i) drops++;
            else if (exp_q.size() < cap) exp_q.push_back('{data: d, lcr: bus.lcr_i});
            else drops++;
        end
        @(posedge clk);
        #1;
        bus.thr_write_i = 1'b0;
    endtask

    task automatic pause_ticks();
        tick_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && mon_state == 0 && bus.tx_empty_o) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, n < budget, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mon_idx(input int target, input int budget, input string tag);
        int n = 0;
        while (!(mon_state == 1 && mon_idx >= target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, n < budget, 1'b1);
    endtask

    initial begin
        int d0, f0, r0, v0, n, r, ones;
        logic [7:0] lcr_v;
        logic [7:0] lcr_tab [3];
        lcr_tab[0] = 8'h1B;
        lcr_tab[1] = 8'h0B;
        lcr_tab[2] = 8'h2B;

        bus.thr_i         = 8'h00;
        bus.thr_write_i   = 1'b0;
        bus.lcr_i         = 8'h03;
        bus.fifo_en_i     = 1'b0;
        bus.tx_fifo_rst_i = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {bus.tx_o, bus.thr_empty_o, bus.tx_empty_o, bus.thr_valid_o,
                 bus.empty_valid_o, bus.fifo_rst_o, bus.fifo_rst_valid_o}, 7'b1110000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 8N1 0x55 and a single tx_empty rise
        r0 = ev_rise;
        push_thr(8'h55, 1'b1);
        wait_idle(3000, "t_8n1_done");
        check_eq("t_8n1_empty_rise", ev_rise - r0, 1);

        // Parity variants on 0x07
        for (int i = 0; i < 3; i++) begin
            bus.lcr_i = lcr_tab[i];
            push_thr(8'h07, 1'b1);
            wait_idle(3000, "t_parity_done");
        end

        // Full FIFO: 17 back-to-back writes, last one dropped
        bus.lcr_i     = 8'h03;
        bus.fifo_en_i = 1'b1;
        pause_ticks();
        d0 = drops;
        for (int i = 0; i <= 16; i++) push_thr(i[7:0], 1'b1);
        check_eq("t_full_drops", drops - d0, 1);
        check_eq("t_full_thr_busy", bus.thr_empty_o, 1'b0);
        f0 = frames_done;
        tick_en = 1'b1;
        wait_idle(20000, "t_full_done");
        check_eq("t_full_frames", frames_done - f0, 16);
        check_eq("t_full_thr_empty", bus.thr_empty_o, 1'b1);

        // Flush during first character's data bits, with a coincident write
        pause_ticks();
        for (int i = 0; i < 4; i++) push_thr(8'hA1 + i[7:0], 1'b1);
        f0 = frames_done;
        v0 = frv_cnt;
        d0 = drops;
        tick_en = 1'b1;
        wait_mon_idx(40, 3000, "t_flush_reach_data");
        @(posedge clk);
        #1;
        bus.tx_fifo_rst_i = 1'b1;
        exp_q.delete();
        push_thr(8'hEE, 1'b1);
        bus.tx_fifo_rst_i = 1'b0;
        check_eq("t_flush_thr_empty", bus.thr_empty_o, 1'b1);
        wait_idle(3000, "t_flush_done");
        check_eq("t_flush_frames", frames_done - f0, 1);
        check_eq("t_flush_pulses", frv_cnt - v0, 1);
        check_eq("t_flush_rst_val", frv_bad, 0);
        check_eq("t_flush_push_drop", drops - d0, 1);

        // 5N1.5: 24-tick stop
        bus.fifo_en_i = 1'b0;
        bus.lcr_i     = 8'h04;
        push_thr(8'h1F, 1'b1);
        wait_idle(3000, "t_stop15_done");

`ifdef UART_TX_BREAK_EN
        // Break holds the line low while the character runs
        mon_en    = 1'b0;
        bus.lcr_i = 8'h44;
        push_thr(8'h1F, 1'b0);
        n = 0;
        ones = 0;
        while (!bus.tx_empty_o && n < 3000) begin
            @(negedge clk);
            n++;
            if (bus.tx_o) ones++;
        end
        check_eq("t_break_timeout", n < 3000, 1'b1);
        check_eq("t_break_ones", ones, 0);
        @(posedge clk);
        #1;
        bus.lcr_i = 8'h04;
        @(posedge clk);
        #1;
        check_eq("t_break_release", bus.tx_o, 1'b1);
        mon_en = 1'b1;
`endif

        // Reset mid data bit aborts the character
        bus.lcr_i = 8'h03;
        push_thr(8'h55, 1'b1);
        wait_mon_idx(40, 3000, "t_rst_reach_data");
        check_eq("t_rst_pre_low", bus.tx_o, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("t_rst_async", {bus.tx_o, bus.thr_empty_o, bus.tx_empty_o}, 3'b111);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        f0 = frames_done;
        push_thr(8'hA5, 1'b1);
        wait_idle(3000, "t_rst_after_done");
        check_eq("t_rst_after_frames", frames_done - f0, 1);

        // Randomized bursts with random line control, changed while characters are in flight
        for (int it = 0; it < 8; it++) begin
            pause_ticks();
            bus.fifo_en_i = 1'($urandom_range(0, 1));
            r = $urandom;
            lcr_v = r[7:0];
`ifdef UART_TX_BREAK_EN
            lcr_v[6] = 1'b0;
`endif
            bus.lcr_i = lcr_v;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                r = $urandom;
                push_thr(r[7:0], 1'b1);
            end
            tick_en = 1'b1;
            n = 0;
            while (exp_q.size() != 0 && n < 20000) begin
                @(negedge clk);
                n++;
            end
            r = $urandom;
            lcr_v = r[7:0];
`ifdef UART_TX_BREAK_EN
            lcr_v[6] = 1'b0;
`endif
            @(posedge clk);
            #1;
            bus.lcr_i = lcr_v;
            wait_idle(5000, "t_rand_done");
        end

        check_eq("thr_valid_rule", th_err, 0);
        check_eq("empty_valid_rule", ev_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
